// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential 32-bit unsigned multiply/divide unit
//
// Purpose: a multi-cycle MUL / MULHU / DIVU / REMU engine. The multiply is
// radix-2 shift-add and the divide is restoring shift-subtract. Both take
// 32 iterations. A divide by zero skips the iterations and completes at once.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   Start  - request a new operation (sampled only in IDLE)
//   Op     - 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   A, B   - operands, captured on acceptance
//   Flush  - abort; forces IDLE and discards any operation in flight
//   Result - registered result of the last completed operation
//   Busy   - high while iterating (CALC)
//   Done   - one-cycle completion pulse (DONE)
//   Stall  - combinational pipeline hold request
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic [31:0] Result,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  // Multiply: {partial product high, multiplier bits still to consume}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q;
  logic [63:0] acc_step;

  logic        accept;
  logic        div_by_zero;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_sub;
  logic        div_borrow;

  assign accept      = (state_q == IDLE) && Start && !Flush;
  assign div_by_zero = Op[1] && (B == 32'd0);

  // One iteration of the selected algorithm.
  always_comb begin
    mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    div_shift  = {acc_q[63:32], acc_q[31]};
    div_sub    = {1'b0, div_shift[31:0]} - {1'b0, b_q};
    // A shifted remainder with bit 32 set always exceeds a 32-bit divisor,
    // so the 33-bit compare borrows only when that bit is clear.
    div_borrow = div_sub[32] && !div_shift[32];
    if (!op_q[1]) begin
      acc_step = {mul_sum, acc_q[31:1]};
    end else if (div_borrow) begin
      acc_step = {div_shift[31:0], acc_q[30:0], 1'b0};
    end else begin
      acc_step = {div_sub[31:0], acc_q[30:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start) state_d = div_by_zero ? DONE : CALC;
      CALC: if (cnt_q == 5'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      Result  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= Op;
        a_q   <= A;
        b_q   <= B;
        cnt_q <= 5'd0;
        acc_q <= Op[1] ? {32'd0, A} : {32'd0, B};
        if (div_by_zero) Result <= Op[0] ? A : 32'hFFFF_FFFF;
      end else if (state_q == CALC && !Flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 5'd1;
        // Odd ops (MULHU, REMU) take the upper half of the accumulator.
        if (cnt_q == 5'd31) Result <= op_q[0] ? acc_step[63:32] : acc_step[31:0];
      end
    end
  end

  assign Busy  = (state_q == CALC);
  assign Done  = (state_q == DONE);
  assign Stall = (Start && (state_q == IDLE) && !Flush) || Busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic [31:0] Result;
  logic        Busy;
  logic        Done;
  logic        Stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Result(Result), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return prod[31:0];
      2'd1:    return prod[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation and follow it to completion. Inputs are scrambled
  // while it runs; a stray Start pulse is optionally injected mid-operation.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit stray_start);
    int n;
    int busy_cycles;
    int exp_n;
    logic [31:0] exp_res;
    exp_res = ref_model(op, a, b);
    exp_n   = (op[1] && b == 0) ? 1 : 33;
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    #1 check("stall_on_start", {31'd0, Stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    n = 1;
    busy_cycles = 0;
    while (!Done && n < 40) begin
      if (Busy) busy_cycles++;
      A  = $urandom;
      B  = $urandom;
      Op = 2'($urandom);
      Start = stray_start && (n == 5);
      @(negedge clk);
      n++;
    end
    Start = 1'b0;
    check($sformatf("done_cycle op%0d", op), n, exp_n);
    check($sformatf("busy_cycles op%0d", op), busy_cycles, exp_n - 1);
    check($sformatf("result op%0d %08h %08h", op, a, b), Result, exp_res);
    @(negedge clk);
    check("done_one_cycle", {31'd0, Done}, 32'd0);
    check("idle_after_done", {31'd0, Busy}, 32'd0);
    check("result_held", Result, exp_res);
  endtask

  initial begin
    logic [31:0] held;
    int saw_done;
    rst = 1'b1; Start = 1'b0; Op = 2'd0; A = 32'd0; B = 32'd0; Flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_result", Result, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_stall", {31'd0, Stall}, 32'd0);

    run_op(2'd0, 32'd7, 32'd6, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd2, 32'd5, 32'd0, 1'b0);
    run_op(2'd3, 32'd5, 32'd0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(2'd3, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'd3, 32'd9, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
      run_op(2'($urandom), ra, rb, 1'b0);
    end

    // Flush at iteration 10 of a multiply.
    held = Result;
    @(negedge clk);
    Start = 1'b1; Op = 2'd0; A = 32'd1234; B = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_flush", {31'd0, Busy}, 32'd1);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", {31'd0, Busy}, 32'd0);
    check("flush_done", {31'd0, Done}, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done || Busy) saw_done = 1;
    end
    check("flush_no_done", saw_done, 0);
    check("flush_result_kept", Result, held);

    // Second Start mid-operation is ignored.
    run_op(2'd0, 32'd1000, 32'd3, 1'b1);
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (Busy || Done) saw_done = 1;
    end
    check("stray_start_ignored", saw_done, 0);

    // Reset at iteration 20.
    @(negedge clk);
    Start = 1'b1; Op = 2'd1; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (19) @(negedge clk);
    check("busy_before_rst", {31'd0, Busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_result", Result, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Done) saw_done = 1;
    end
    check("rst_no_done", saw_done, 0);

    // Start together with Flush in IDLE stays idle.
    Start = 1'b1; Flush = 1'b1; Op = 2'd0; A = 32'd2; B = 32'd3;
    #1 check("start_flush_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    check("start_flush_busy", {31'd0, Busy}, 32'd0);
    check("start_flush_done", {31'd0, Done}, 32'd0);
    Start = 1'b0; Flush = 1'b0;

    // Engine still works afterwards.
    run_op(2'd0, 32'd7, 32'd6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
